// File: rtl/hilo_muldiv_controller_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide sequencer: operation
// codes, sequencer states, datapath width and small op-decode helpers.
package mips_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = WIDTH;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } state_e;

    // Codes 6 and 7 are reserved and never start anything.
    function automatic logic op_is_valid(input logic [2:0] op);
        return op <= 3'd5;
    endfunction

    // MULT, MULTU, DIV, DIVU need the iterative datapath.
    function automatic logic op_is_arith(input logic [2:0] op);
        return op <= 3'd3;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_controller_if.sv
// Request/response bundle between EX and the Hi/Lo sequencer. The master
// side (EX, flush logic) drives the request; the slave side (sequencer)
// drives status and the Hi/Lo write ports.
interface hilo_muldiv_controller_if #(
    parameter int WIDTH = mips_pkg::WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             hi_enable;
    logic             lo_enable;
    logic [WIDTH-1:0] hi_pw;
    logic [WIDTH-1:0] lo_pw;

    modport master (
        output start, op, rs_val, rt_val, cancel,
        input  busy, done, hi_enable, lo_enable, hi_pw, lo_pw
    );

    modport slave (
        input  start, op, rs_val, rt_val, cancel,
        output busy, done, hi_enable, lo_enable, hi_pw, lo_pw
    );
endinterface

// File: rtl/hilo_muldiv_controller_muldiv_iter_datapath.sv
// Iterative datapath: one shift-add multiply step or one restoring divide
// step per strobe, on operand magnitudes. The sign fix-up is applied to the
// result of the final step so the controller can register it directly.
module muldiv_iter_datapath #(
    parameter int WIDTH = mips_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_finish,
    input  logic             i_is_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_res_hi,
    output logic [WIDTH-1:0] o_res_lo
);
    // r_acc: product high half / partial remainder
    // r_q:   multiplier shifting out / dividend shifting out, quotient in
    // r_b:   multiplicand / divisor magnitude
    logic [WIDTH-1:0]   r_acc, r_q, r_b;
    logic               r_is_div, r_neg_q, r_neg_r;

    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_addend;
    logic [WIDTH:0]     w_sum, w_shift;
    logic [WIDTH-1:0]   w_sub, w_div_acc, w_div_q, w_mul_acc, w_mul_q;
    logic [WIDTH-1:0]   w_acc_next, w_q_next;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic               w_ge;

    assign w_mag_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // Shift-add: add the multiplicand when the multiplier LSB is set, then
    // shift the {acc, q} pair right by one.
    assign w_addend  = r_q[0] ? r_b : '0;
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_mul_acc = w_sum[WIDTH:1];
    assign w_mul_q   = {w_sum[0], r_q[WIDTH-1:1]};

    // Restoring divide: the shifted remainder is below 2*divisor, so when it
    // is >= divisor the true difference fits in WIDTH bits.
    assign w_shift   = {r_acc, r_q[WIDTH-1]};
    assign w_ge      = w_shift[WIDTH] || (w_shift[WIDTH-1:0] >= r_b);
    assign w_sub     = w_shift[WIDTH-1:0] - r_b;
    assign w_div_acc = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign w_div_q   = {r_q[WIDTH-2:0], w_ge};

    assign w_acc_next = r_is_div ? w_div_acc : w_mul_acc;
    assign w_q_next   = r_is_div ? w_div_q   : w_mul_q;

    assign w_prod     = {w_acc_next, w_q_next};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -w_q_next : w_q_next;
    assign w_rem_fix  = r_neg_r ? -w_acc_next : w_acc_next;

    // Results are only meaningful alongside the final step; hold them at 0
    // otherwise so the wide negators do not toggle during the iterations.
    assign o_res_hi = !i_finish ? '0 : (r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH]);
    assign o_res_lo = !i_finish ? '0 : (r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0]);

    // Load magnitudes and sign flags on start, advance one iteration per step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_q      <= w_mag_a;
            r_b      <= w_mag_b;
            r_is_div <= i_is_div;
            r_neg_q  <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r  <= i_signed && i_is_div && i_a[WIDTH-1];
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_q      <= w_q_next;
        end
    end

endmodule

// File: rtl/hilo_muldiv_controller.sv
// Hi/Lo sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Accepts a request in
// IDLE, iterates the datapath ITER times in CALC, then drives the Hi/Lo
// write ports for exactly one WRITE cycle. busy stalls the pipeline.
module hilo_muldiv_controller #(
    parameter int WIDTH = mips_pkg::WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    hilo_muldiv_controller_if.slave  bus
);
    import mips_pkg::*;

    localparam int             CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0]  LAST = CW'(ITER - 1);

    state_e           r_state, w_state_next;
    logic [CW-1:0]    r_cnt;
    logic             r_busy, r_done, r_hi_en, r_lo_en;
    logic [WIDTH-1:0] r_hi_pw, r_lo_pw;

    logic             w_busy_next, w_done_next, w_hi_en_next, w_lo_en_next;
    logic [WIDTH-1:0] w_hi_pw_next, w_lo_pw_next;
    logic             w_load, w_step, w_finish;
    logic             w_accept, w_div_zero, w_is_div, w_signed;
    logic [WIDTH-1:0] w_res_hi, w_res_lo;

    assign w_accept   = bus.start && op_is_valid(bus.op) && !bus.cancel;
    assign w_is_div   = op_is_div(bus.op);
    assign w_signed   = op_is_signed(bus.op);
    assign w_div_zero = w_is_div && (bus.rt_val == '0);

    muldiv_iter_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_finish (w_finish),
        .i_is_div (w_is_div),
        .i_signed (w_signed),
        .i_a      (bus.rs_val),
        .i_b      (bus.rt_val),
        .o_res_hi (w_res_hi),
        .o_res_lo (w_res_lo)
    );

    // State and iteration counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load)
                r_cnt <= '0;
            else if (w_step)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    // Next state, datapath strobes and the next values of every registered output.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_hi_en_next = 1'b0;
        w_lo_en_next = 1'b0;
        w_hi_pw_next = r_hi_pw;
        w_lo_pw_next = r_lo_pw;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (op_is_arith(bus.op) && !w_div_zero) begin
                        w_load       = 1'b1;
                        w_state_next = CALC;
                    end else begin
                        // MTHI/MTLO and divide-by-zero skip the iterations;
                        // divide-by-zero writes neither register.
                        w_state_next = WRITE;
                        if (bus.op == OP_MTHI) begin
                            w_hi_en_next = 1'b1;
                            w_hi_pw_next = bus.rs_val;
                        end
                        if (bus.op == OP_MTLO) begin
                            w_lo_en_next = 1'b1;
                            w_lo_pw_next = bus.rs_val;
                        end
                    end
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    w_state_next = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == LAST) begin
                        w_finish     = 1'b1;
                        w_state_next = WRITE;
                        w_hi_en_next = 1'b1;
                        w_lo_en_next = 1'b1;
                        w_hi_pw_next = w_res_hi;
                        w_lo_pw_next = w_res_lo;
                    end
                end
            end
            WRITE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        w_busy_next = (w_state_next != IDLE);
        w_done_next = (w_state_next == WRITE);
    end

    // Output registers; pw values hold between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi_en <= 1'b0;
            r_lo_en <= 1'b0;
            r_hi_pw <= '0;
            r_lo_pw <= '0;
        end else begin
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_hi_en <= w_hi_en_next;
            r_lo_en <= w_lo_en_next;
            r_hi_pw <= w_hi_pw_next;
            r_lo_pw <= w_lo_pw_next;
        end
    end

    // A squash arriving during WRITE must stop the Hi/Lo capture in that
    // same cycle, so the strobes are masked by cancel on the way out.
    assign bus.busy      = r_busy;
    assign bus.done      = r_done  && !bus.cancel;
    assign bus.hi_enable = r_hi_en && !bus.cancel;
    assign bus.lo_enable = r_lo_en && !bus.cancel;
    assign bus.hi_pw     = r_hi_pw;
    assign bus.lo_pw     = r_lo_pw;

endmodule
